arbiter_n_to_1_request_cache: RTL and testbench

//  Merges MemoryPacketRequest streams from NUM_MEMORY_REQUESTOR engines into one stream toward the cache.
//  - Each requestor gets a per-input buffer.
//  - A round-robin arbiter moves one request per cycle into a FWFT output FIFO.
//  - Return path is the 1-to-N request/response demux, which routes on id_channel.

---
 rtl/arbiter_n_to_1_request_cache.sv | 166 ++++++++++++++++
 tb/tb_arbiter_n_to_1_request_cache.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_n_to_1_request_cache.sv
// Merges N requestor streams into one FWFT request stream toward the cache (round-robin, one grant per cycle).
// Optional ARBITER_REQUEST_ID_STAMP_EN: id_channel of each granted payload is overwritten with the one-hot port id.
module arbiter_n_to_1_request_cache #(
    parameter int NUM_MEMORY_REQUESTOR = 2,
    parameter int INPUT_FIFO_DEPTH     = 4,
    parameter int OUTPUT_FIFO_DEPTH    = 16,
    parameter int PROG_THRESH          = OUTPUT_FIFO_DEPTH / 2 + 3,
    parameter int PAYLOAD_WIDTH        = 32,
    parameter int ID_CHANNEL_LSB       = 0
) (
    input  logic                                                ap_clk,
    input  logic                                                areset_n,
    input  logic [NUM_MEMORY_REQUESTOR-1:0]                     request_in_valid,
    input  logic [NUM_MEMORY_REQUESTOR-1:0][PAYLOAD_WIDTH-1:0]  request_in_payload,
    output logic [NUM_MEMORY_REQUESTOR-1:0]                     request_in_prog_full,
    output logic                                                request_out_valid,
    output logic [PAYLOAD_WIDTH-1:0]                            request_out_payload,
    input  logic                                                request_out_rd_en,
    output logic                                                request_out_prog_full,
    output logic [NUM_MEMORY_REQUESTOR-1:0]                     overflow_error,
    output logic                                                fifo_setup_signal
);
    localparam int N  = NUM_MEMORY_REQUESTOR;
    localparam int IA = $clog2(INPUT_FIFO_DEPTH);
    localparam int OA = $clog2(OUTPUT_FIFO_DEPTH);
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IA:0] IN_FULL  = (IA+1)'(INPUT_FIFO_DEPTH);
    localparam logic [IA:0] IN_PF    = (IA+1)'(INPUT_FIFO_DEPTH - 2);
    localparam logic [OA:0] OUT_FULL = (OA+1)'(OUTPUT_FIFO_DEPTH);
    localparam logic [OA:0] OUT_PF   = (OA+1)'(PROG_THRESH);

    // Reset asserts asynchronously but releases two edges after areset_n rises.
    logic [1:0] sync_reg;
    logic       rst_n;

    always_ff @(posedge ap_clk or negedge areset_n) begin
        if (!areset_n) sync_reg <= 2'b00;
        else           sync_reg <= {sync_reg[0], 1'b1};
    end

    assign rst_n             = sync_reg[1];
    assign fifo_setup_signal = ~rst_n;

    logic [N-1:0]                    in_valid_reg;
    logic [N-1:0][PAYLOAD_WIDTH-1:0] in_payload_reg;

    always_ff @(posedge ap_clk or negedge rst_n) begin
        if (!rst_n) begin
            in_valid_reg   <= '0;
            in_payload_reg <= '0;
        end else begin
            in_valid_reg   <= request_in_valid;
            in_payload_reg <= request_in_payload;
        end
    end

    logic [N-1:0]                    buf_empty;
    logic [N-1:0]                    buf_pop;
    logic [N-1:0][PAYLOAD_WIDTH-1:0] buf_head;
    logic [RW-1:0]                   grant_idx;
    logic [RW-1:0]                   rr_ptr_reg;
    logic [RW-1:0]                   rr_next;
    logic                            grant_found;
    logic                            out_push;
    logic                            out_pop;
    logic [PAYLOAD_WIDTH-1:0]        push_payload;
    int                              scan_idx;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_in
            logic [PAYLOAD_WIDTH-1:0] mem [INPUT_FIFO_DEPTH];
            logic [IA-1:0]            wr_ptr_reg;
            logic [IA-1:0]            rd_ptr_reg;
            logic [IA:0]              count_reg;
            logic                     overflow_reg;
            logic                     full;
            logic                     wr_en;

            // A pop on the same edge frees the slot, so a full buffer still accepts.
            assign full        = (count_reg == IN_FULL);
            assign wr_en       = in_valid_reg[gi] & (~full | buf_pop[gi]);
            assign buf_pop[gi] = out_push & (grant_idx == RW'(gi));

            always_ff @(posedge ap_clk) begin
                if (wr_en) mem[wr_ptr_reg] <= in_payload_reg[gi];
            end

            always_ff @(posedge ap_clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_reg   <= '0;
                    rd_ptr_reg   <= '0;
                    count_reg    <= '0;
                    overflow_reg <= 1'b0;
                end else begin
                    if (wr_en)       wr_ptr_reg <= wr_ptr_reg + IA'(1);
                    if (buf_pop[gi]) rd_ptr_reg <= rd_ptr_reg + IA'(1);
                    count_reg <= count_reg + (IA+1)'(wr_en) - (IA+1)'(buf_pop[gi]);
                    if (in_valid_reg[gi] & ~wr_en) overflow_reg <= 1'b1;
                end
            end

            assign buf_head[gi]             = mem[rd_ptr_reg];
            assign buf_empty[gi]            = (count_reg == '0);
            assign request_in_prog_full[gi] = ~rst_n | (count_reg >= IN_PF);
            assign overflow_error[gi]       = overflow_reg;
        end
    endgenerate

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 0; k < N; k++) begin
            scan_idx = (int'(rr_ptr_reg) + k) % N;
            if (!grant_found && !buf_empty[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = RW'(scan_idx);
            end
        end
        rr_next = RW'((int'(grant_idx) + 1) % N);
    end

`ifdef ARBITER_REQUEST_ID_STAMP_EN
    logic [N-1:0] stamp;
`endif

    always_comb begin
        push_payload = buf_head[grant_idx];
`ifdef ARBITER_REQUEST_ID_STAMP_EN
        stamp            = '0;
        stamp[grant_idx] = 1'b1;
        push_payload[ID_CHANNEL_LSB +: N] = stamp;
`endif
    end

    logic [PAYLOAD_WIDTH-1:0] out_mem [OUTPUT_FIFO_DEPTH];
    logic [OA-1:0]            out_wr_ptr_reg;
    logic [OA-1:0]            out_rd_ptr_reg;
    logic [OA:0]              out_count_reg;

    assign out_pop  = request_out_rd_en & request_out_valid;
    assign out_push = grant_found & ((out_count_reg != OUT_FULL) | out_pop);

    always_ff @(posedge ap_clk) begin
        if (out_push) out_mem[out_wr_ptr_reg] <= push_payload;
    end

    always_ff @(posedge ap_clk or negedge rst_n) begin
        if (!rst_n) begin
            out_wr_ptr_reg <= '0;
            out_rd_ptr_reg <= '0;
            out_count_reg  <= '0;
            rr_ptr_reg     <= '0;
        end else begin
            if (out_push) out_wr_ptr_reg <= out_wr_ptr_reg + OA'(1);
            if (out_pop)  out_rd_ptr_reg <= out_rd_ptr_reg + OA'(1);
            out_count_reg <= out_count_reg + (OA+1)'(out_push) - (OA+1)'(out_pop);
            if (out_push) rr_ptr_reg <= rr_next;
        end
    end

    assign request_out_valid     = (out_count_reg != '0);
    assign request_out_payload   = out_mem[out_rd_ptr_reg];
    assign request_out_prog_full = (out_count_reg >= OUT_PF);
endmodule

// File: tb/tb_arbiter_n_to_1_request_cache.sv
// Randomized and directed bench for arbiter_n_to_1_request_cache (N=4) against a per-port queue model.
module tb_arbiter_n_to_1_request_cache;
    localparam int N  = 4;
    localparam int PW = 32;

    logic                 ap_clk = 1'b0;
    logic                 areset_n = 1'b1;
    logic [N-1:0]         request_in_valid = '0;
    logic [N-1:0][PW-1:0] request_in_payload = '0;
    logic [N-1:0]         request_in_prog_full;
    logic                 request_out_valid;
    logic [PW-1:0]        request_out_payload;
    logic                 request_out_rd_en = 1'b0;
    logic                 request_out_prog_full;
    logic [N-1:0]         overflow_error;
    logic                 fifo_setup_signal;

    int checks = 0;
    int passed = 0;
    logic [7:0]    seq_cnt = 8'd0;
    logic [PW-1:0] exp_q [N][$];
    logic [PW-1:0] exp_v;

    arbiter_n_to_1_request_cache #(
        .NUM_MEMORY_REQUESTOR(N),
        .INPUT_FIFO_DEPTH(4),
        .OUTPUT_FIFO_DEPTH(16),
        .PROG_THRESH(11),
        .PAYLOAD_WIDTH(PW),
        .ID_CHANNEL_LSB(0)
    ) dut (
        .ap_clk(ap_clk),
        .areset_n(areset_n),
        .request_in_valid(request_in_valid),
        .request_in_payload(request_in_payload),
        .request_in_prog_full(request_in_prog_full),
        .request_out_valid(request_out_valid),
        .request_out_payload(request_out_payload),
        .request_out_rd_en(request_out_rd_en),
        .request_out_prog_full(request_out_prog_full),
        .overflow_error(overflow_error),
        .fifo_setup_signal(fifo_setup_signal)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Payload layout: {random[15:0], seq[7:0], port[3:0], id_channel[3:0]}.
    task automatic drive_port(input int p);
        logic [15:0]   r;
        logic [3:0]    id;
        logic [PW-1:0] v;
        logic [PW-1:0] e;
        r  = 16'($urandom());
        id = 4'($urandom());
        v  = {r, seq_cnt, 4'(p), id};
        seq_cnt = seq_cnt + 8'd1;
        e = v;
`ifdef ARBITER_REQUEST_ID_STAMP_EN
        e[3:0] = 4'b0001 << p;
`endif
        request_in_valid[p]   = 1'b1;
        request_in_payload[p] = v;
        exp_q[p].push_back(e);
    endtask

    function automatic logic [PW-1:0] model_pop(input logic [PW-1:0] obs);
        int p;
        p = int'(obs[7:4]);
        if (p < N && exp_q[p].size() > 0) return exp_q[p].pop_front();
        return ~obs;
    endfunction

    function automatic int queued();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += exp_q[i].size();
        return s;
    endfunction

    task automatic do_reset();
        areset_n = 1'b0;
        request_in_valid = '0;
        request_out_rd_en = 1'b0;
        for (int i = 0; i < N; i++) exp_q[i].delete();
        tick();
        tick();
        areset_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        #1 areset_n = 1'b0;
        #1;
        checks++; if (request_out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", request_out_valid); else passed++;
        checks++; if (request_in_prog_full !== 4'hF) $display("FAIL rst_in_prog_full: got %h expected f", request_in_prog_full); else passed++;
        checks++; if (request_out_prog_full !== 1'b0) $display("FAIL rst_out_prog_full: got %b expected 0", request_out_prog_full); else passed++;
        checks++; if (overflow_error !== 4'h0) $display("FAIL rst_overflow: got %h expected 0", overflow_error); else passed++;
        checks++; if (fifo_setup_signal !== 1'b1) $display("FAIL rst_setup: got %b expected 1", fifo_setup_signal); else passed++;
        tick();
        areset_n = 1'b1;
        tick();
        checks++; if (fifo_setup_signal !== 1'b1) $display("FAIL rst_setup_edge1: got %b expected 1", fifo_setup_signal); else passed++;
        tick();
        checks++; if (fifo_setup_signal !== 1'b0) $display("FAIL rst_setup_edge2: got %b expected 0", fifo_setup_signal); else passed++;
        checks++; if (request_in_prog_full !== 4'h0) $display("FAIL rst_in_pf_release: got %h expected 0", request_in_prog_full); else passed++;
    endtask

    task automatic test_latency();
        drive_port(1);
        tick();
        request_in_valid = '0;
        checks++; if (request_out_valid !== 1'b0) $display("FAIL lat_edge0: got %b expected 0", request_out_valid); else passed++;
        tick();
        checks++; if (request_out_valid !== 1'b0) $display("FAIL lat_edge1: got %b expected 0", request_out_valid); else passed++;
        tick();
        checks++; if (request_out_valid !== 1'b1) $display("FAIL lat_edge2: got %b expected 1", request_out_valid); else passed++;
        exp_v = model_pop(request_out_payload);
        checks++; if (request_out_payload !== exp_v) $display("FAIL lat_payload: got %h expected %h", request_out_payload, exp_v); else passed++;
        request_out_rd_en = 1'b1;
        tick();
        request_out_rd_en = 1'b0;
        checks++; if (request_out_valid !== 1'b0) $display("FAIL lat_popped: got %b expected 0", request_out_valid); else passed++;
    endtask

    task automatic test_round_robin();
        int  exp_port;
        bit  started;
        do_reset();
        exp_port = 0;
        started = 1'b0;
        request_out_rd_en = 1'b1;
        for (int c = 0; c < 48; c++) begin
            if (started || request_out_valid) begin
                started = 1'b1;
                checks++; if (request_out_valid !== 1'b1) $display("FAIL rr_gap: cycle %0d valid %b expected 1", c, request_out_valid); else passed++;
                if (request_out_valid) begin
                    checks++; if (request_out_payload[7:4] !== 4'(exp_port)) $display("FAIL rr_order: got port %0d expected %0d", request_out_payload[7:4], exp_port); else passed++;
                    exp_v = model_pop(request_out_payload);
                    checks++; if (request_out_payload !== exp_v) $display("FAIL rr_payload: got %h expected %h", request_out_payload, exp_v); else passed++;
                end
                exp_port = (exp_port + 1) % N;
            end
            request_in_valid = '0;
            for (int p = 0; p < N; p++) if (!request_in_prog_full[p]) drive_port(p);
            tick();
        end
        request_in_valid = '0;
        for (int c = 0; c < 120; c++) begin
            if (request_out_valid) begin
                exp_v = model_pop(request_out_payload);
                checks++; if (request_out_payload !== exp_v) $display("FAIL rr_drain: got %h expected %h", request_out_payload, exp_v); else passed++;
            end
            tick();
        end
        request_out_rd_en = 1'b0;
        checks++; if (queued() !== 0 || overflow_error !== 4'h0) $display("FAIL rr_end: left %0d overflow %h expected 0 0", queued(), overflow_error); else passed++;
    endtask

    task automatic test_fill_prog_full();
        int e;
        int cnt;
        do_reset();
        for (int c = 0; c < 31; c++) begin
            if (c > 0) begin
                e = c - 1;
                cnt = (e - 1 < 0) ? 0 : ((e - 1 > 16) ? 16 : e - 1);
                checks++; if (request_out_prog_full !== (cnt >= 11)) $display("FAIL fill_prog_full: edge %0d got %b expected %b", e, request_out_prog_full, cnt >= 11); else passed++;
                checks++; if (request_out_valid !== (cnt > 0)) $display("FAIL fill_valid: edge %0d got %b expected %b", e, request_out_valid, cnt > 0); else passed++;
            end
            request_in_valid = '0;
            if (!request_in_prog_full[0]) drive_port(0);
            tick();
        end
        request_in_valid = '0;
        checks++; if (request_in_prog_full[0] !== 1'b1) $display("FAIL fill_in_pf: got %b expected 1", request_in_prog_full[0]); else passed++;
        checks++; if (overflow_error !== 4'h0) $display("FAIL fill_overflow: got %h expected 0", overflow_error); else passed++;
        request_out_rd_en = 1'b1;
        for (int c = 0; c < 120; c++) begin
            if (request_out_valid) begin
                exp_v = model_pop(request_out_payload);
                checks++; if (request_out_payload !== exp_v) $display("FAIL fill_drain: got %h expected %h", request_out_payload, exp_v); else passed++;
            end
            tick();
        end
        request_out_rd_en = 1'b0;
        checks++; if (queued() !== 0 || request_out_valid !== 1'b0) $display("FAIL fill_end: left %0d valid %b expected 0 0", queued(), request_out_valid); else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int c = 0; c < 22; c++) begin
            request_in_valid = '0;
            if (!request_in_prog_full[1]) drive_port(1);
            tick();
        end
        request_in_valid = '0;
        tick();
        tick();
        for (int k = 0; k < 6; k++) begin
            request_in_valid = '0;
            drive_port(0);
            if (k >= 4) void'(exp_q[0].pop_back());
            tick();
        end
        request_in_valid = '0;
        repeat (3) tick();
        checks++; if (overflow_error !== 4'b0001) $display("FAIL ovf_set: got %b expected 0001", overflow_error); else passed++;
        request_out_rd_en = 1'b1;
        for (int c = 0; c < 120; c++) begin
            if (request_out_valid) begin
                exp_v = model_pop(request_out_payload);
                checks++; if (request_out_payload !== exp_v) $display("FAIL ovf_drain: got %h expected %h", request_out_payload, exp_v); else passed++;
            end
            tick();
        end
        request_out_rd_en = 1'b0;
        checks++; if (overflow_error !== 4'b0001) $display("FAIL ovf_sticky: got %b expected 0001", overflow_error); else passed++;
        checks++; if (queued() !== 0 || request_out_valid !== 1'b0) $display("FAIL ovf_end: left %0d valid %b expected 0 0", queued(), request_out_valid); else passed++;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            request_in_valid = '0;
            drive_port(0);
            tick();
        end
        request_in_valid = '0;
        repeat (5) tick();
        for (int c = 0; c < 2; c++) begin
            request_in_valid = '0;
            drive_port(1);
            tick();
        end
        request_in_valid = '0;
        repeat (4) tick();
        checks++; if (request_in_prog_full !== 4'b0010) $display("FAIL fpp_before: got %b expected 0010", request_in_prog_full); else passed++;
        checks++; if (request_out_prog_full !== 1'b1) $display("FAIL fpp_out_pf: got %b expected 1", request_out_prog_full); else passed++;
        request_out_rd_en = 1'b1;
        exp_v = model_pop(request_out_payload);
        checks++; if (request_out_payload !== exp_v) $display("FAIL fpp_head: got %h expected %h", request_out_payload, exp_v); else passed++;
        tick();
        request_out_rd_en = 1'b0;
        checks++; if (request_in_prog_full !== 4'b0000) $display("FAIL fpp_same_edge: got %b expected 0000", request_in_prog_full); else passed++;
        tick();
        checks++; if (request_in_prog_full !== 4'b0000) $display("FAIL fpp_hold: got %b expected 0000", request_in_prog_full); else passed++;
        checks++; if (request_out_prog_full !== 1'b1) $display("FAIL fpp_still_full: got %b expected 1", request_out_prog_full); else passed++;
        request_out_rd_en = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (request_out_valid) begin
                exp_v = model_pop(request_out_payload);
                checks++; if (request_out_payload !== exp_v) $display("FAIL fpp_drain: got %h expected %h", request_out_payload, exp_v); else passed++;
            end
            tick();
        end
        request_out_rd_en = 1'b0;
        checks++; if (queued() !== 0 || request_out_valid !== 1'b0) $display("FAIL fpp_end: left %0d valid %b expected 0 0", queued(), request_out_valid); else passed++;
    endtask

    task automatic test_reset_flush();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            request_in_valid = '0;
            drive_port(2);
            tick();
        end
        request_in_valid = '0;
        repeat (4) tick();
        checks++; if (request_out_valid !== 1'b1) $display("FAIL rf_queued: got %b expected 1", request_out_valid); else passed++;
        #3 areset_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) exp_q[i].delete();
        checks++; if (request_out_valid !== 1'b0) $display("FAIL rf_async_valid: got %b expected 0", request_out_valid); else passed++;
        checks++; if (fifo_setup_signal !== 1'b1) $display("FAIL rf_setup: got %b expected 1", fifo_setup_signal); else passed++;
        checks++; if (request_in_prog_full !== 4'hF) $display("FAIL rf_in_pf: got %h expected f", request_in_prog_full); else passed++;
        checks++; if (request_out_prog_full !== 1'b0) $display("FAIL rf_out_pf: got %b expected 0", request_out_prog_full); else passed++;
        tick();
        tick();
        areset_n = 1'b1;
        tick();
        checks++; if (fifo_setup_signal !== 1'b1) $display("FAIL rf_setup_edge1: got %b expected 1", fifo_setup_signal); else passed++;
        tick();
        checks++; if (fifo_setup_signal !== 1'b0) $display("FAIL rf_setup_edge2: got %b expected 0", fifo_setup_signal); else passed++;
        request_out_rd_en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++; if (request_out_valid !== 1'b0) $display("FAIL rf_no_stale: cycle %0d got %b expected 0", c, request_out_valid); else passed++;
            tick();
        end
        request_out_rd_en = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            request_out_rd_en = ($urandom % 100) < 65;
            if (request_out_rd_en && request_out_valid) begin
                exp_v = model_pop(request_out_payload);
                checks++; if (request_out_payload !== exp_v) $display("FAIL rnd_payload: got %h expected %h", request_out_payload, exp_v); else passed++;
            end
            request_in_valid = '0;
            for (int p = 0; p < N; p++)
                if (!request_in_prog_full[p] && ($urandom % 100) < 50) drive_port(p);
            tick();
        end
        request_in_valid = '0;
        request_out_rd_en = 1'b1;
        for (int c = 0; c < 120; c++) begin
            if (request_out_valid) begin
                exp_v = model_pop(request_out_payload);
                checks++; if (request_out_payload !== exp_v) $display("FAIL rnd_drain: got %h expected %h", request_out_payload, exp_v); else passed++;
            end
            tick();
        end
        request_out_rd_en = 1'b0;
        checks++; if (queued() !== 0 || overflow_error !== 4'h0) $display("FAIL rnd_end: left %0d overflow %h expected 0 0", queued(), overflow_error); else passed++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_round_robin();
        test_fill_prog_full();
        test_overflow();
        test_full_push_pop();
        test_reset_flush();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
